// File: rtl/cfg_chain_loader.sv
// Parallel-to-serial configuration master for the stream cipher chain.
// Writes a word LSB-first while capturing the previous chain contents.
module cfg_chain_loader #(
  parameter int M = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [4*M+2:0] cfg_data,
  output logic [4*M+2:0] rd_data,
  output logic           rd_valid,
  output logic           busy,
  output logic           cfg_en,
  output logic           cfg_i,
  input  logic           cfg_o
);

  localparam int W  = 4*M+3;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  tx_q, tx_d;
  logic [W-1:0]  rx_q, rx_d;
  logic [W-1:0]  rd_q, rd_d;
  logic          en_q, en_d;
  logic          bit_q, bit_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rd_q    <= '0;
      en_q    <= 1'b0;
      bit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rd_q    <= rd_d;
      en_q    <= en_d;
      bit_q   <= bit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rd_d    = rd_q;
    en_d    = en_q;
    bit_d   = bit_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          // bit 0 goes out now, the rest waits in tx_q
          tx_d    = cfg_data >> 1;
          bit_d   = cfg_data[0];
          en_d    = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        rx_d  = {cfg_o, rx_q[W-1:1]};
        bit_d = tx_q[0];
        tx_d  = tx_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W-1)) begin
          en_d    = 1'b0;
          bit_d   = 1'b0;
          rd_d    = rx_d;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rd_valid  = (state_q == DONE);
  assign rd_data   = rd_q;
  assign cfg_en    = en_q;
  assign cfg_i     = bit_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader with a behavioural cipher chain model.
// Runs W=11 vectors and corner cases, plus one W=131 load.
module tb_cfg_chain_loader;
  localparam int M  = 2;
  localparam int W  = 4*M+3;
  localparam int M2 = 32;
  localparam int W2 = 4*M2+3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic cfg_valid, cfg_ready, rd_valid, busy;
  logic cfg_en, cfg_i, cfg_o;
  logic [W-1:0] cfg_data, rd_data;

  logic cfg_valid2, cfg_ready2, rd_valid2, busy2;
  logic cfg_en2, cfg_i2, cfg_o2;
  logic [W2-1:0] cfg_data2, rd_data2;

  cfg_chain_loader #(.M(M)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy),
    .cfg_en(cfg_en), .cfg_i(cfg_i), .cfg_o(cfg_o)
  );

  cfg_chain_loader #(.M(M2)) dut2 (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid2), .cfg_ready(cfg_ready2),
    .cfg_data(cfg_data2), .rd_data(rd_data2),
    .rd_valid(rd_valid2), .busy(busy2),
    .cfg_en(cfg_en2), .cfg_i(cfg_i2), .cfg_o(cfg_o2)
  );

  // cipher cfg chain: shift right, insert at MSB, expose bit 0
  logic [W-1:0]  creg, m_val;
  logic [W2-1:0] creg2, m_val2;
  logic          m_load;

  always @(posedge clk) begin
    if (m_load) creg <= m_val;
    else if (cfg_en) creg <= {cfg_i, creg[W-1:1]};
    if (m_load) creg2 <= m_val2;
    else if (cfg_en2) creg2 <= {cfg_i2, creg2[W2-1:1]};
  end
  assign cfg_o  = creg[0];
  assign cfg_o2 = creg2[0];

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] exp_rd;
  } vec_t;

  vec_t vt[6];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [W2-1:0] act,
                     input logic [W2-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_load(input logic [W-1:0] d,
                         output logic [W-1:0] rd,
                         output logic [W-1:0] sent,
                         output int nen, output int lat, output int nrv);
    int waitc;
    waitc = 0;
    while (!cfg_ready && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    chk("ready_wait", {130'd0, cfg_ready}, 131'd1);
    cfg_valid = 1'b1;
    cfg_data  = d;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    cfg_data  = ~d;
    rd = '0; sent = '0; nen = 0; lat = -1; nrv = 0;
    for (int c = 0; c < W + 4; c++) begin
      if (cfg_en) begin
        if (nen < W) sent[nen] = cfg_i;
        nen++;
      end
      if (rd_valid) begin
        nrv++;
        if (lat < 0) begin
          rd  = rd_data;
          lat = c;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  logic [W-1:0]  rd, sent, snap;
  logic [W2-1:0] pre2, dat2, rd2;
  int nen, lat, nrv, acc, last, gaps_bad, rb_bad, rvc, lat2;
  logic prev_en;

  initial begin
    vt[0] = '{11'h5A3, 11'h2B4};
    vt[1] = '{11'h1C6, 11'h5A3};
    vt[2] = '{11'h7FF, 11'h1C6};
    vt[3] = '{11'h000, 11'h7FF};
    vt[4] = '{11'h400, 11'h000};
    vt[5] = '{11'h001, 11'h400};
    pre2 = {3'b110, 32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D, 32'h0BADC0DE};
    dat2 = {3'b001, 32'h48000000, 32'h00000001, 32'h48000000, 32'h00000001};

    rst = 1'b1; cfg_valid = 1'b0; cfg_data = '0;
    cfg_valid2 = 1'b0; cfg_data2 = '0;
    m_load = 1'b1; m_val = 11'h2B4; m_val2 = pre2;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; m_load = 1'b0;

    chk("rst_cfg_en",   cfg_en,    0);
    chk("rst_cfg_i",    cfg_i,     0);
    chk("rst_ready",    cfg_ready, 1);
    chk("rst_busy",     busy,      0);
    chk("rst_rd_valid", rd_valid,  0);
    chk("rst_rd_data",  rd_data,   0);
    chk("rst_rd_data2", rd_data2,  0);

    for (int i = 0; i < 6; i++) begin
      do_load(vt[i].data, rd, sent, nen, lat, nrv);
      chk($sformatf("v%0d_rd", i),   rd,   vt[i].exp_rd);
      chk($sformatf("v%0d_sent", i), sent, vt[i].data);
      chk($sformatf("v%0d_creg", i), creg, vt[i].data);
      chk($sformatf("v%0d_nen", i),  nen,  W);
      chk($sformatf("v%0d_lat", i),  lat,  W);
      chk($sformatf("v%0d_nrv", i),  nrv,  1);
    end

    // back-to-back with cfg_valid held high
    cfg_valid = 1'b1; cfg_data = 11'h2C9;
    prev_en = cfg_en; acc = 0; last = -1; gaps_bad = 0; rb_bad = 0;
    for (int c = 0; c < 52; c++) begin
      @(posedge clk); #1;
      if (cfg_en && !prev_en) begin
        if (last >= 0 && c - last != W + 2) gaps_bad++;
        last = c;
        acc++;
      end
      prev_en = cfg_en;
      if (busy && cfg_ready) rb_bad++;
    end
    cfg_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_accepts", acc, 4);
    chk("b2b_gaps", gaps_bad, 0);
    chk("b2b_ready_busy", rb_bad, 0);
    chk("b2b_creg", creg, 11'h2C9);

    // reset in the middle of a shift
    cfg_valid = 1'b1; cfg_data = 11'h0F0;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_en_before", cfg_en, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_cfg_en", cfg_en, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ready", cfg_ready, 1);
    rvc = 0;
    for (int c = 0; c < 15; c++) begin
      if (rd_valid) rvc++;
      @(posedge clk); #1;
    end
    chk("mid_no_rd_valid", rvc, 0);
    snap = creg;
    do_load(11'h3C5, rd, sent, nen, lat, nrv);
    chk("post_rd", rd, snap);
    chk("post_creg", creg, 11'h3C5);
    chk("post_lat", lat, W);

    // reset and valid in the same cycle
    rst = 1'b1; cfg_valid = 1'b1; cfg_data = 11'h7AA;
    @(posedge clk); #1;
    rst = 1'b0; cfg_valid = 1'b0;
    chk("rv_cfg_en", cfg_en, 0);
    chk("rv_busy", busy, 0);
    @(posedge clk); #1;
    chk("rv_cfg_en2", cfg_en, 0);
    chk("rv_ready", cfg_ready, 1);
    chk("rv_creg", creg, 11'h3C5);

    // full-width load
    cfg_valid2 = 1'b1; cfg_data2 = dat2;
    @(posedge clk); #1;
    cfg_valid2 = 1'b0; cfg_data2 = ~dat2;
    lat2 = -1; rd2 = '0;
    for (int c = 0; c < W2 + 10 && lat2 < 0; c++) begin
      if (rd_valid2) begin
        lat2 = c;
        rd2  = rd_data2;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("w131_lat", lat2, W2);
    chk("w131_rd", rd2, pre2);
    chk("w131_creg", creg2, dat2);
    chk("w131_d_en", creg2[128], 1);
    chk("w131_en_low", cfg_en2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cfg_chain_loader.md
# cfg_chain_loader

Parallel-to-serial configuration master for `dual_xor_stream_cipher`. It accepts a full configuration word over a valid/ready handshake and drives the cipher's `cfg_en`/`cfg_i` serial chain for exactly 4*M+3 contiguous cycles. During the same cycles it captures the previous chain contents from `cfg_o`, giving simultaneous write and readback. It sits directly upstream of the cipher's configuration port.

## Interface
- `M`, 32, cipher LFSR width. Chain length is W = 4*M+3.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_valid`  in  1  a new configuration word is offered.
- `cfg_ready`  out  1  the loader can accept a word. High only in IDLE.
- `cfg_data`  in  W  word to load, with the same bit layout as the cipher `cfg_reg`: {k_mux, a_mux, d_en, tx_taps, tx_state, rx_taps, rx_state}.
- `rd_data`  out  W  chain contents captured during the last load.
- `rd_valid`  out  1  one-cycle pulse; `rd_data` is fresh.
- `busy`  out  1  high in SHIFT and DONE.
- `cfg_en`  out  1  to the cipher `cfg_en`. Registered.
- `cfg_i`  out  1  to the cipher `cfg_i`. Registered.
- `cfg_o`  in  1  from the cipher `cfg_o`, which equals the cipher `cfg_reg[0]` while `cfg_en`=1.

## Operation
- The cipher shifts right and inserts `cfg_i` at its MSB. After W shifts, the first bit sent sits at bit 0. The loader therefore sends `cfg_data[0]` first, LSB-first.
- State IDLE:
  - `cfg_ready`=1.
  - On `cfg_valid`&&`cfg_ready`: latch `cfg_data` into the tx shift register, set `cfg_en`<=1, `cfg_i`<=`cfg_data[0]`, `cnt`<=0, and go to SHIFT.
  - `cfg_data` is don't-care after acceptance.
- State SHIFT, on each edge:
  - Capture `cfg_o` into the rx shift register at its MSB, shifting right.
  - Present the next tx bit on `cfg_i`.
  - Increment `cnt`.
  - When `cnt`==W-1: `cfg_en`<=0, `cfg_i`<=0, copy the rx shift register (including this edge's captured bit) to `rd_data`, and go to DONE.
- State DONE: `rd_valid`=1 for exactly one cycle, then go to IDLE.
- Bit ordering: after a load, `rd_data[i]` equals the old cipher `cfg_reg[i]` for all i. The capture order mirrors the send order.
- `cnt` width is clog2(W). It never wraps within a load because it is reset on acceptance.
- `cfg_valid` in SHIFT or DONE is ignored and not queued. `cfg_ready`=0 in those states.
- Readback of the LFSR state fields reflects the live LFSR state. It is only meaningful if the cipher `tx_en`/`rx_en` were low before the load. The loader does not gate them.

## Timing
- Reset values:
  - state=IDLE.
  - `cfg_en`=0, `cfg_i`=0, `cfg_ready`=1, `busy`=0, `rd_valid`=0.
  - `rd_data`=0, `cnt`=0, shift registers=0.
- Handshake accepted at edge E0.
- `cfg_en` is high from E0 to E_W, i.e. exactly W consecutive cycles. This matches the cipher's internal counter, so it raises `ld` once.
- The bit presented after edge E_k (k=0..W-1) is `cfg_data[k]`. The cipher samples it at edge E_{k+1}.
- `cfg_o` is sampled at edges E1..E_W. The sample at E_{k+1} is old bit k.
- `rd_valid` is high in the cycle after E_W. `cfg_ready` returns high at E_{W+1}.
- Back-to-back throughput: one word per W+2 cycles.
- `rst` mid-SHIFT: the next edge forces reset values, so `cfg_en` drops immediately. The cipher chain is left partially shifted and `rst` must also be applied to the cipher. `rd_valid` is not asserted.
- `rst` and `cfg_valid` in the same cycle: reset wins and the word is not accepted.

## Test plan
Run the loader with M=2 (W=11) against the cipher, plus one run at M=32 (W=131).
- Reset, then `cfg_valid`=1 with `cfg_data`=11'h5A3 -> `cfg_en` high exactly 11 cycles; `cfg_i` sequence 1,1,0,0,0,1,0,1,1,0,1; the cipher `cfg_reg`==11'h5A3 afterwards.
- Load 11'h5A3, then load 11'h1C6 -> the second `rd_valid` pulse shows `rd_data`==11'h5A3, and the cipher `cfg_reg`==11'h1C6.
- Hold `cfg_valid`=1 continuously -> acceptances spaced exactly 13 cycles apart; `cfg_ready`=0 throughout SHIFT/DONE; no extra loads.
- Assert `rst` at the 5th SHIFT cycle -> `cfg_en`=0 and `busy`=0 on the next cycle; no `rd_valid`; the following load completes normally.
- M=32, load 131'h... with `cfg_data[130:128]`=3'b001 and taps 32'h48000000 -> the cipher `d_en`=1; `dbg_tx_p` equals `tx_p` once `tx_en` is raised.
- Single cycle with `rst`=1 and `cfg_valid`=1 -> no acceptance; `cfg_en` stays 0.
